// File: rtl/mips_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_controller
//  Description : Sequences the single-cycle MiniMIPS datapath one instruction
//                at a time (FETCH -> EXEC -> COMMIT). Owns the PC register,
//                gates architectural writes with exec_en, and supports
//                free-run / single-step operation with breakpoint,
//                instruction-count and external-stop halting.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   datapath_clk  in   clock; all state updates on its rising edge
//   reset         in   asynchronous active-high reset
//   start         in   begin a run at start_pc (honoured in IDLE/HALTED only)
//   start_pc      in   first instruction address
//   step_mode     in   1 = pause after every committed instruction
//   step          in   release one instruction while paused
//   stop          in   request halt at the next instruction boundary
//   halt_pc       in   breakpoint address (halt before executing it)
//   max_instr     in   halt after this many commits, 0 = unlimited
//   pc_next       in   next PC computed by the datapath
//   pc            out  current PC, drives datapath pc_new
//   exec_en       out  write enable, high one cycle per instruction
//   busy          out  high in FETCH, EXEC, COMMIT
//   halted        out  high in HALTED
//   halt_cause    out  0 none, 1 breakpoint, 2 count limit, 3 stop
//   instr_count   out  instructions committed since the last start
// ============================================================================
module mips_run_controller #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             datapath_clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  start_pc,
   input  logic             step_mode,
   input  logic             step,
   input  logic             stop,
   input  logic [PC_W-1:0]  halt_pc,
   input  logic [CNT_W-1:0] max_instr,
   input  logic [PC_W-1:0]  pc_next,
   output logic [PC_W-1:0]  pc,
   output logic             exec_en,
   output logic             busy,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [1:0] c_CAUSE_NONE = 2'd0;
   localparam logic [1:0] c_CAUSE_BP   = 2'd1;
   localparam logic [1:0] c_CAUSE_CNT  = 2'd2;
   localparam logic [1:0] c_CAUSE_STOP = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_PAUSED = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic [1:0]       r_halt_cause;
   logic [CNT_W-1:0] r_instr_count;

   // Count after the instruction currently in COMMIT retires; wraps naturally.
   logic [CNT_W-1:0] w_count_inc;
   logic             w_count_hit;

   assign w_count_inc = r_instr_count + CNT_W'(1);
   // A zero limit means unlimited, so it must never match a wrapped count.
   assign w_count_hit = (max_instr != '0) && (w_count_inc == max_instr);

   always_ff @(posedge datapath_clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_halt_cause  <= c_CAUSE_NONE;
         r_instr_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  r_pc          <= start_pc;
                  r_instr_count <= '0;
                  // Breakpoint on the very first address: never execute it.
                  if (start_pc == halt_pc) begin
                     r_halt_cause <= c_CAUSE_BP;
                     r_state      <= ST_HALTED;
                  end else begin
                     r_halt_cause <= c_CAUSE_NONE;
                     r_state      <= ST_FETCH;
                  end
               end
            end

            ST_FETCH: r_state <= ST_EXEC;

            // stop is deliberately not looked at here; an instruction that
            // has started executing always reaches COMMIT.
            ST_EXEC: r_state <= ST_COMMIT;

            ST_COMMIT: begin
               r_pc          <= pc_next;
               r_instr_count <= w_count_inc;
               if (pc_next == halt_pc) begin
                  r_halt_cause <= c_CAUSE_BP;
                  r_state      <= ST_HALTED;
               end else if (w_count_hit) begin
                  r_halt_cause <= c_CAUSE_CNT;
                  r_state      <= ST_HALTED;
               end else if (stop) begin
                  r_halt_cause <= c_CAUSE_STOP;
                  r_state      <= ST_HALTED;
               end else if (step_mode) begin
                  r_state <= ST_PAUSED;
               end else begin
                  r_state <= ST_FETCH;
               end
            end

            ST_PAUSED: begin
               // stop has priority over a simultaneous step request.
               if (stop) begin
                  r_halt_cause <= c_CAUSE_STOP;
                  r_state      <= ST_HALTED;
               end else if (step || !step_mode) begin
                  r_state <= ST_FETCH;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Status outputs are pure state decodes, so reset clears them at once.
   assign pc          = r_pc;
   assign exec_en     = (r_state == ST_EXEC);
   assign busy        = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                        (r_state == ST_COMMIT);
   assign halted      = (r_state == ST_HALTED);
   assign halt_cause  = r_halt_cause;
   assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_run_controller
//  Description : Self-checking bench for mips_run_controller. Directed table
//                of complete runs, hand-written multi-cycle sequences, and
//                randomized runs checked cycle by cycle against an
//                arithmetic model of the instruction stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_run_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] start_pc;
   logic        step_mode;
   logic        step;
   logic        stop;
   logic [31:0] halt_pc;
   logic [15:0] max_instr;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic        exec_en;
   logic        busy;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [15:0] instr_count;

   // Stand-in datapath: next PC is the current PC plus a programmable stride.
   logic [31:0] stride;
   assign pc_next = pc + stride;

   int n_tests = 0;
   int n_fail  = 0;

   mips_run_controller #(.PC_W(32), .CNT_W(16)) dut (
      .datapath_clk (clk),
      .reset        (reset),
      .start        (start),
      .start_pc     (start_pc),
      .step_mode    (step_mode),
      .step         (step),
      .stop         (stop),
      .halt_pc      (halt_pc),
      .max_instr    (max_instr),
      .pc_next      (pc_next),
      .pc           (pc),
      .exec_en      (exec_en),
      .busy         (busy),
      .halted       (halted),
      .halt_cause   (halt_cause),
      .instr_count  (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] spc);
      start_pc = spc;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Returns edges after the start edge until halted, and exec_en pulses seen.
   task automatic run_to_halt(input int budget, output int edges, output int pulses);
      edges  = 0;
      pulses = 0;
      while (!halted && edges < budget) begin
         if (exec_en) pulses++;
         tick();
         edges++;
      end
   endtask

   typedef struct {
      logic [31:0] spc;
      logic [31:0] hpc;
      logic [15:0] maxi;
      logic [31:0] strd;
      int          edges;
      logic [31:0] epc;
      logic [15:0] ecnt;
      logic [1:0]  ecause;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int edges, pulses, e;

      vecs[0] = '{32'd0,          32'd35,         16'd0, 32'd1, 105, 32'd35,     16'd35, 2'd1};
      vecs[1] = '{32'd8,          32'hFFFF_FFFF,  16'd4, 32'd1,  12, 32'd12,     16'd4,  2'd2};
      vecs[2] = '{32'd40,         32'd40,         16'd0, 32'd1,   0, 32'd40,     16'd0,  2'd1};
      vecs[3] = '{32'd0,          32'd3,          16'd3, 32'd1,   9, 32'd3,      16'd3,  2'd1};
      vecs[4] = '{32'hFFFF_FFFE,  32'd1,          16'd0, 32'd1,   9, 32'd1,      16'd3,  2'd1};
      vecs[5] = '{32'd0,          32'd10,         16'd6, 32'd2,  15, 32'd10,     16'd5,  2'd1};
      vecs[6] = '{32'h1000,       32'd0,          16'd1, 32'd4,   3, 32'h1004,   16'd1,  2'd2};

      reset = 1'b1; start = 1'b0; start_pc = '0; step_mode = 1'b0; step = 1'b0;
      stop = 1'b0; halt_pc = 32'hFFFF_FFFF; max_instr = '0; stride = 32'd1;
      tick(); tick();
      check("reset_pc", pc, 32'd0);
      check("reset_flags", {exec_en, busy, halted}, 3'b000);
      check("reset_cnt_cause", {instr_count, halt_cause}, 18'd0);
      #2 reset = 1'b0;
      tick();
      check("idle_after_reset", {exec_en, busy, halted}, 3'b000);

      // ---- single-step mode ----
      step_mode = 1'b1; stride = 32'd1; halt_pc = 32'hFFFF_FFFF; max_instr = '0;
      do_start(32'd0);
      tick(); tick(); tick();
      check("step_first_pause_pc", pc, 32'd1);
      check("step_first_pause_flags", {exec_en, busy, halted}, 3'b000);
      tick(); tick();
      check("step_pause_hold_pc", pc, 32'd1);
      for (int rep = 0; rep < 2; rep++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         pulses = 0;
         for (int i = 0; i < 6; i++) begin
            if (exec_en) pulses++;
            tick();
         end
         check("step_one_pulse", pulses, 1);
         check("step_pc_advance", pc, 32'(2 + rep));
         check("step_paused_again", {busy, halted}, 2'b00);
      end
      stop = 1'b1; step = 1'b1;
      tick();
      stop = 1'b0; step = 1'b0;
      check("step_stop_wins_halted", halted, 1'b1);
      check("step_stop_cause", halt_cause, 2'd3);
      check("step_stop_pc", pc, 32'd3);
      check("step_stop_cnt", instr_count, 16'd3);
      step_mode = 1'b0;

      // ---- self-loop with stop raised in EXEC of instruction 3 ----
      stride = 32'd0; halt_pc = 32'hFFFF_FFFF; max_instr = '0;
      do_start(32'h200);
      for (int i = 0; i < 7; i++) tick();
      check("loop_exec3_en", exec_en, 1'b1);
      check("loop_exec3_cnt", instr_count, 16'd2);
      stop = 1'b1;
      tick();
      check("loop_not_halted_in_commit", halted, 1'b0);
      tick();
      check("loop_halted", halted, 1'b1);
      check("loop_pc_cnt_cause", {pc, instr_count, halt_cause}, {32'h200, 16'd3, 2'd3});
      stop = 1'b0;

      // ---- start while busy is ignored ----
      stride = 32'd1; halt_pc = 32'hFFFF_FFFF; max_instr = 16'd3;
      do_start(32'd100);
      tick();
      start_pc = 32'd500; start = 1'b1;
      tick();
      start = 1'b0;
      e = 2;
      while (!halted && e < 60) begin
         tick();
         e++;
      end
      check("busy_start_edges", e, 9);
      check("busy_start_result", {pc, instr_count, halt_cause}, {32'd103, 16'd3, 2'd2});

      // ---- directed table of complete runs (each restarts from HALTED) ----
      foreach (vecs[k]) begin
         halt_pc   = vecs[k].hpc;
         max_instr = vecs[k].maxi;
         stride    = vecs[k].strd;
         do_start(vecs[k].spc);
         if (vecs[k].edges > 0)
            check($sformatf("tbl%0d_restart_clear", k), {instr_count, halt_cause}, 18'd0);
         run_to_halt(400, edges, pulses);
         check($sformatf("tbl%0d_halt_edge", k), edges, vecs[k].edges);
         check($sformatf("tbl%0d_exec_pulses", k), pulses, int'(vecs[k].ecnt));
         check($sformatf("tbl%0d_pc", k), pc, vecs[k].epc);
         check($sformatf("tbl%0d_cnt", k), instr_count, vecs[k].ecnt);
         check($sformatf("tbl%0d_cause", k), halt_cause, vecs[k].ecause);
      end

      // ---- asynchronous reset during EXEC ----
      stride = 32'd1; halt_pc = 32'hFFFF_FFFF; max_instr = '0;
      do_start(32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("rst_exec_pre", {exec_en, pc, instr_count}, {1'b1, 32'd1, 16'd1});
      #2 reset = 1'b1;
      #1;
      check("rst_exec_flags", {exec_en, busy, halted}, 3'b000);
      check("rst_exec_regs", {pc, instr_count, halt_cause}, 50'd0);
      #2 reset = 1'b0;
      tick();
      check("rst_exec_stays_idle", {busy, halted, pc}, 34'd0);

      // ---- randomized runs against an arithmetic model ----
      for (int r = 0; r < 40; r++) begin
         logic [31:0] spc, hpc, strd, e_pc;
         logic [15:0] mx, e_cnt;
         logic [1:0]  cause, e_cause;
         logic        e_exec, e_busy, e_halt;
         int          n_exp;

         strd = 32'($urandom_range(0, 3));
         spc  = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 64));
         mx   = 16'($urandom_range(1, 12));
         case ($urandom_range(0, 2))
            0:       hpc = spc + strd * 32'($urandom_range(0, 14));
            1:       hpc = $urandom;
            default: hpc = spc;
         endcase

         // Commits needed: first n whose target hits the breakpoint,
         // otherwise the count limit.
         if (spc == hpc) begin
            n_exp = 0; cause = 2'd1;
         end else begin
            n_exp = int'(mx); cause = 2'd2;
            for (int n = 1; n <= int'(mx); n++) begin
               if (spc + 32'(n) * strd == hpc) begin
                  n_exp = n; cause = 2'd1;
                  break;
               end
            end
         end

         stride = strd; halt_pc = hpc; max_instr = mx;
         do_start(spc);
         for (int c = 0; c <= 3 * n_exp + 1; c++) begin
            if (c < 3 * n_exp) begin
               e_exec = (c % 3 == 1); e_busy = 1'b1; e_halt = 1'b0;
               e_pc = spc + 32'(c / 3) * strd; e_cnt = 16'(c / 3); e_cause = 2'd0;
            end else begin
               e_exec = 1'b0; e_busy = 1'b0; e_halt = 1'b1;
               e_pc = spc + 32'(n_exp) * strd; e_cnt = 16'(n_exp); e_cause = cause;
            end
            check($sformatf("rnd%0d_c%0d_flags", r, c), {exec_en, busy, halted}, {e_exec, e_busy, e_halt});
            check($sformatf("rnd%0d_c%0d_pc", r, c), pc, e_pc);
            check($sformatf("rnd%0d_c%0d_cnt_cause", r, c), {instr_count, halt_cause}, {e_cnt, e_cause});
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
